regfile_wport_ctrl: RTL and testbench
=====================================

Name: regfile_wport_ctrl

Overview:
- Controller in front of the 32x32 register file.
- Shares the file's single write port (en_w/addr_w/data_w) between two writers: the pipeline writeback stage and the multi-cycle mult/div unit (MDU).
- Keeps a busy scoreboard of registers with an outstanding MDU result, and flags read hazards on the two read channels.
- Sits between the WB stage, the MDU and regfile; hazard outputs feed the ID-stage stall logic.

Parameters:
- MAX_WAIT, 4: cycles a valid MDU result may be refused before it gets priority over WB (1..15).
- ADDR_WIDTH, 5: register address width.
- DATA_WIDTH, 32: register data width.

Ports:
- clk  in  1  main clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_en  in  1  WB stage wants to write this cycle.
- wb_addr  in  ADDR_WIDTH  WB destination.
- wb_data  in  DATA_WIDTH  WB data.
- stall_wb  out  1  WB write refused this cycle; WB must hold its request.
- md_issue  in  1  MDU op issued this cycle.
- md_issue_addr  in  ADDR_WIDTH  destination of the issued MDU op.
- issue_block  out  1  issue refused: destination already busy.
- md_valid  in  1  MDU result available.
- md_addr  in  ADDR_WIDTH  MDU result destination.
- md_data  in  DATA_WIDTH  MDU result data.
- md_ready  out  1  MDU result written this cycle.
- rd_addr_a  in  ADDR_WIDTH  read channel A address.
- rd_addr_b  in  ADDR_WIDTH  read channel B address.
- hazard_a  out  1  channel A register busy.
- hazard_b  out  1  channel B register busy.
- en_w  out  1  regfile write enable.
- addr_w  out  ADDR_WIDTH  regfile write address.
- data_w  out  DATA_WIDTH  regfile write data.
- busy  out  32  scoreboard vector, debug; bit 0 is always 0.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n). Reset clears busy to 0 and wait_cnt to 0.
- Output style: all outputs are combinational from the inputs and registered state, so the grant and write happen in the same cycle as the request; no added latency.
- force: force = md_valid && (wait_cnt == MAX_WAIT).
- Grant, MDU wins when md_valid && (!wb_en || force):
  - md_ready=1, en_w=1, addr_w=md_addr, data_w=md_data.
  - stall_wb=wb_en.
- Grant, WB wins when wb_en and the MDU does not win:
  - en_w=1, addr_w=wb_addr, data_w=wb_data.
  - md_ready=0, stall_wb=0.
- Neither requesting: en_w=0, md_ready=0, stall_wb=0, addr_w/data_w=0.
- wait_cnt (4 bits):
  - md_valid && !md_ready: increment, saturating at MAX_WAIT.
  - md_ready, or md_valid low: clear to 0.
  - The forced grant therefore occurs on the (MAX_WAIT+1)th cycle of continuous refusal.
- Scoreboard busy[31:1], registered:
  - Set: md_issue && !issue_block && md_issue_addr!=0 sets busy[md_issue_addr].
  - Clear: md_valid && md_ready clears busy[md_addr].
  - Same-edge set and clear on the same address: set wins.
  - Address 0 is never marked busy.
- issue_block = md_issue && md_issue_addr!=0 && busy[md_issue_addr] (WAW on the MDU). A blocked issue does not change state; the issuer retries.
- hazard_a = rd_addr_a!=0 && busy[rd_addr_a]; hazard_b likewise.
  - Hazards stay asserted during the completing cycle (conservative). They deassert the cycle after the write, which matches regfile's negedge read after the posedge write.
- WB writes to a busy register: allowed; they do not clear busy, and the later MDU write overwrites.
- en_w is asserted for address-0 writes; regfile discards them.
- Reset mid-operation: busy and wait_cnt clear immediately; a pending md_valid is arbitrated afresh after reset release.
- Write ordering: MDU results return in any order; the controller imposes no ordering beyond one write per cycle.

Decomposition:
- Shared package/header (define.vh): ADDR_WIDTH, DATA_WIDTH, REG_COUNT=32, MAX_WAIT default.
- One natural sub-module, regfile_scoreboard: busy vector, set/clear priority, hazard and issue_block lookups.
- Arbitration and wait_cnt stay in the top module.

Test Plan:
- Reset release, all inputs 0 -> en_w=0, md_ready=0, stall_wb=0, busy=0.
- wb_en=1, wb_addr=5, wb_data=0xDEADBEEF, md_valid=0 -> same cycle en_w=1, addr_w=5, data_w=0xDEADBEEF, stall_wb=0.
- md_issue, md_issue_addr=8 -> next cycle busy[8]=1; rd_addr_a=8 -> hazard_a=1.
  - Then md_valid, md_addr=8, md_data=0x1234, wb_en=0 -> md_ready=1, addr_w=8.
  - Next cycle busy[8]=0, hazard_a=0.
- wb_en held 1 with md_valid=1 (addr 9), MAX_WAIT=4 -> md_ready=0 for 4 cycles.
  - 5th cycle: md_ready=1, stall_wb=1, addr_w=9.
  - Following cycle WB is granted.
- busy[3]=1, md_issue with addr 3 -> issue_block=1, busy unchanged.
  - Same-edge issue 3 and completion 3 -> busy[3]=1 afterwards.
- Issue to addr 0 -> busy stays 0, issue_block=0. Assert rst_n=0 with busy[12]=1 and wait_cnt=2 -> busy=0 and wait_cnt=0 immediately, without a clock edge.

Source files
------------

// File: rtl/regfile_wport_ctrl_pkg.sv
// Shared definitions for the register-file write-port controller.
//   REG_ADDR_WIDTH / REG_DATA_WIDTH : default register address / data widths
//   REG_COUNT                       : number of architectural registers
//   MAX_WAIT_DEFAULT                : default refusal budget before the MDU is forced
//   WAIT_CNT_WIDTH                  : width of the MDU refusal counter
//   grant_e                         : which writer owns the write port this cycle
package regfile_wport_ctrl_pkg;

    localparam int REG_ADDR_WIDTH   = 5;
    localparam int REG_DATA_WIDTH   = 32;
    localparam int REG_COUNT        = 32;
    localparam int MAX_WAIT_DEFAULT = 4;
    localparam int WAIT_CNT_WIDTH   = 4;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WB   = 2'd1,
        GRANT_MD   = 2'd2
    } grant_e;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [WAIT_CNT_WIDTH-1:0] wait_sat_inc(
        input logic [WAIT_CNT_WIDTH-1:0] cnt,
        input logic [WAIT_CNT_WIDTH-1:0] limit
    );
        return (cnt >= limit) ? limit : cnt + WAIT_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/regfile_wport_ctrl_scoreboard.sv
// Busy scoreboard for registers with an outstanding MDU result.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   issue, issue_addr     : MDU issue request and its destination
//   clr, clr_addr         : MDU result written this cycle and its destination
//   rd_addr_a, rd_addr_b  : read-channel addresses to look up
//   issue_block           : issue refused because destination is already busy
//   hazard_a, hazard_b    : read-channel register busy
//   busy                  : registered busy vector (bit 0 always 0)
module regfile_scoreboard
    import regfile_wport_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  issue_block,
    output logic                  hazard_a,
    output logic                  hazard_b,
    output logic [REG_COUNT-1:0]  busy
);

    logic                 set_req;
    logic [REG_COUNT-1:0] busy_next;

    // Lookups use the registered vector, so a register completing this cycle
    // still reads as busy until the edge that writes it.
    assign issue_block = issue && (issue_addr != '0) && busy[issue_addr];
    assign hazard_a    = (rd_addr_a != '0) && busy[rd_addr_a];
    assign hazard_b    = (rd_addr_b != '0) && busy[rd_addr_b];
    assign set_req     = issue && !issue_block && (issue_addr != '0);

    // Clear first, then set: a new issue to the register completing on the
    // same edge leaves it busy.
    always_comb begin
        busy_next = busy;
        if (clr) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_req) begin
            busy_next[issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_wport_ctrl.sv
// Write-port controller in front of the 32x32 register file.
// Shares the single write port between the WB stage and the MDU, tracks
// registers with outstanding MDU results and flags read hazards.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   wb_en/wb_addr/wb_data, stall_wb  : WB write request, refused-this-cycle flag
//   md_issue/md_issue_addr           : MDU issue and destination
//   issue_block                      : issue refused (destination busy)
//   md_valid/md_addr/md_data         : MDU result request
//   md_ready                         : MDU result written this cycle
//   rd_addr_a/b, hazard_a/b          : read-channel hazard lookups
//   en_w/addr_w/data_w               : register-file write port
//   busy                             : scoreboard vector (debug)
module regfile_wport_ctrl
    import regfile_wport_ctrl_pkg::*;
#(
    parameter int MAX_WAIT   = MAX_WAIT_DEFAULT,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  stall_wb,
    input  logic                  md_issue,
    input  logic [ADDR_WIDTH-1:0] md_issue_addr,
    output logic                  issue_block,
    input  logic                  md_valid,
    input  logic [ADDR_WIDTH-1:0] md_addr,
    input  logic [DATA_WIDTH-1:0] md_data,
    output logic                  md_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  hazard_a,
    output logic                  hazard_b,
    output logic                  en_w,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [DATA_WIDTH-1:0] data_w,
    output logic [REG_COUNT-1:0]  busy
);

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LIMIT = WAIT_CNT_WIDTH'(MAX_WAIT);

    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    logic                      force_grant;
    grant_e                    grant;

    // Once the MDU has been refused MAX_WAIT cycles in a row it takes the
    // port even against WB, so a busy WB stream cannot starve it.
    assign force_grant = md_valid && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        grant = GRANT_NONE;
        if (md_valid && (!wb_en || force_grant)) begin
            grant = GRANT_MD;
        end else if (wb_en) begin
            grant = GRANT_WB;
        end
    end

    always_comb begin
        en_w     = 1'b0;
        addr_w   = '0;
        data_w   = '0;
        md_ready = 1'b0;
        stall_wb = 1'b0;
        case (grant)
            GRANT_MD: begin
                en_w     = 1'b1;
                addr_w   = md_addr;
                data_w   = md_data;
                md_ready = 1'b1;
                stall_wb = wb_en;
            end
            GRANT_WB: begin
                en_w   = 1'b1;
                addr_w = wb_addr;
                data_w = wb_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (md_valid && !md_ready) begin
            wait_cnt <= wait_sat_inc(wait_cnt, WAIT_LIMIT);
        end else begin
            wait_cnt <= '0;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (md_issue),
        .issue_addr  (md_issue_addr),
        .clr         (md_ready),
        .clr_addr    (md_addr),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .issue_block (issue_block),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .busy        (busy)
    );

endmodule

// File: tb/tb_regfile_wport_ctrl.sv
// Self-checking bench for regfile_wport_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wport_ctrl;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        stall_wb;
    logic        md_issue = 1'b0;
    logic [4:0]  md_issue_addr = '0;
    logic        issue_block;
    logic        md_valid = 1'b0;
    logic [4:0]  md_addr = '0;
    logic [31:0] md_data = '0;
    logic        md_ready;
    logic [4:0]  rd_addr_a = '0;
    logic [4:0]  rd_addr_b = '0;
    logic        hazard_a;
    logic        hazard_b;
    logic        en_w;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    regfile_wport_ctrl #(
        .MAX_WAIT   (MAX_WAIT),
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .stall_wb      (stall_wb),
        .md_issue      (md_issue),
        .md_issue_addr (md_issue_addr),
        .issue_block   (issue_block),
        .md_valid      (md_valid),
        .md_addr       (md_addr),
        .md_data       (md_data),
        .md_ready      (md_ready),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .hazard_a      (hazard_a),
        .hazard_b      (hazard_b),
        .en_w          (en_w),
        .addr_w        (addr_w),
        .data_w        (data_w),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // refusals: consecutive cycles a valid MDU result has been turned away.
    bit m_busy[32];
    int refusals;

    function automatic bit m_md_wins();
        return md_valid && (!wb_en || refusals >= MAX_WAIT);
    endfunction

    function automatic bit m_blocked();
        return md_issue && md_issue_addr != 0 && m_busy[md_issue_addr];
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            refusals = 0;
        end else begin
            bit wins, blk;
            wins = m_md_wins();
            blk  = m_blocked();
            if (md_valid && !wins) refusals = refusals + 1;
            else refusals = 0;
            if (wins) m_busy[md_addr] = 1'b0;
            if (md_issue && !blk && md_issue_addr != 0) m_busy[md_issue_addr] = 1'b1;
        end
    end

    // One compare per cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            bit wins;
            logic [4:0]  ea;
            logic [31:0] ed;
            wins = m_md_wins();
            ea = wins ? md_addr : (wb_en ? wb_addr : 5'd0);
            ed = wins ? md_data : (wb_en ? wb_data : 32'd0);
            chk("m_en_w", en_w, md_valid || wb_en);
            chk("m_addr_w", addr_w, ea);
            chk("m_data_w", data_w, ed);
            chk("m_md_ready", md_ready, wins);
            chk("m_stall_wb", stall_wb, wb_en && wins);
            chk("m_issue_block", issue_block, m_blocked());
            chk("m_hazard_a", hazard_a, rd_addr_a != 0 && m_busy[rd_addr_a]);
            chk("m_hazard_b", hazard_b, rd_addr_b != 0 && m_busy[rd_addr_b]);
            chk("m_busy", busy, m_busy_vec());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_en = 0; md_issue = 0; md_valid = 0;
        wb_addr = 0; wb_data = 0; md_issue_addr = 0; md_addr = 0; md_data = 0;
        rd_addr_a = 0; rd_addr_b = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen_ready;

        idle_inputs();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        cyc();
        chk_en = 1'b1;

        // Reset state
        #1;
        chk("rst_en_w", en_w, 0);
        chk("rst_md_ready", md_ready, 0);
        chk("rst_stall_wb", stall_wb, 0);
        chk("rst_busy", busy, 0);

        // Plain WB write, same-cycle grant
        cyc();
        wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        #1;
        chk("wb_en_w", en_w, 1);
        chk("wb_addr_w", addr_w, 5);
        chk("wb_data_w", data_w, 32'hDEADBEEF);
        chk("wb_stall", stall_wb, 0);

        // Issue to 8, hazard, completion, hazard drop
        cyc();
        wb_en = 0; md_issue = 1; md_issue_addr = 8;
        cyc();
        md_issue = 0; rd_addr_a = 8;
        #1;
        chk("iss8_busy8", busy[8], 1);
        chk("iss8_hazard_a", hazard_a, 1);
        cyc();
        md_valid = 1; md_addr = 8; md_data = 32'h1234;
        #1;
        chk("cmp8_md_ready", md_ready, 1);
        chk("cmp8_addr_w", addr_w, 8);
        chk("cmp8_data_w", data_w, 32'h1234);
        chk("cmp8_hazard_held", hazard_a, 1);
        cyc();
        md_valid = 0;
        #1;
        chk("cmp8_busy8_clr", busy[8], 0);
        chk("cmp8_hazard_a_clr", hazard_a, 0);

        // Starvation guard: WB held, MDU result for 9 forced on 5th cycle
        rd_addr_a = 0;
        md_issue = 1; md_issue_addr = 9;
        cyc();
        md_issue = 0;
        wb_en = 1; wb_addr = 10; wb_data = 32'hAAAA0000;
        md_valid = 1; md_addr = 9; md_data = 32'h55;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) cyc();
            #1;
            chk("starve_md_ready", md_ready, 0);
            chk("starve_addr_w", addr_w, 10);
            chk("starve_stall", stall_wb, 0);
        end
        cyc();
        #1;
        chk("force_md_ready", md_ready, 1);
        chk("force_stall_wb", stall_wb, 1);
        chk("force_addr_w", addr_w, 9);
        cyc();
        md_valid = 0;
        #1;
        chk("after_force_addr_w", addr_w, 10);
        chk("after_force_stall", stall_wb, 0);
        chk("after_force_busy9", busy[9], 0);

        // WAW block on 3, then blocked issue coinciding with completion,
        // then legitimate issue and completion of 3 on the same edge.
        cyc();
        wb_en = 0; md_issue = 1; md_issue_addr = 3;
        #1;
        chk("iss3_block", issue_block, 0);
        cyc();
        #1;
        chk("iss3_again_block", issue_block, 1);
        cyc();
        #1;
        chk("iss3_busy_kept", busy, 32'h0000_0008);
        md_valid = 1; md_addr = 3; md_data = 32'h33;
        cyc();
        md_issue = 0; md_valid = 0;
        #1;
        chk("blk_cmp3_busy", busy, 32'h0);
        md_issue = 1; md_issue_addr = 3;
        md_valid = 1; md_addr = 3;
        #1;
        chk("same_edge_block", issue_block, 0);
        chk("same_edge_md_ready", md_ready, 1);
        cyc();
        md_issue = 0; md_valid = 0;
        #1;
        chk("same_edge_set_wins", busy[3], 1);

        // Issue to register 0 is ignored
        md_issue = 1; md_issue_addr = 0;
        #1;
        chk("iss0_block", issue_block, 0);
        cyc();
        md_issue = 0;
        #1;
        chk("iss0_busy", busy, 32'h0000_0008);

        // Asynchronous reset with busy[12] set and wait_cnt at 2
        md_issue = 1; md_issue_addr = 12;
        cyc();
        md_issue = 0;
        wb_en = 1; wb_addr = 1; md_valid = 1; md_addr = 5; md_data = 32'h77;
        cyc();
        cyc();
        #1;
        chk("pre_rst_busy12", busy[12], 1);
        chk("pre_rst_wait_cnt", dut.wait_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_wait_cnt", dut.wait_cnt, 0);
        #3 rst_n = 1'b1;
        // Pending md_valid is arbitrated afresh: forced only after 4 more edges
        for (int i = 1; i <= 4; i++) begin
            cyc();
            #1;
            chk("post_rst_md_ready", md_ready, (i == 4) ? 1 : 0);
        end
        cyc();
        idle_inputs();

        // Randomized traffic; MDU holds its result until it is accepted
        seen_ready = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!md_valid || seen_ready) begin
                md_valid = ($urandom_range(0, 99) < 45);
                md_addr  = 5'($urandom_range(0, 7));
                md_data  = $urandom;
            end
            wb_en         = ($urandom_range(0, 99) < 70);
            wb_addr       = 5'($urandom_range(0, 31));
            wb_data       = $urandom;
            md_issue      = ($urandom_range(0, 99) < 30);
            md_issue_addr = 5'($urandom_range(0, 7));
            rd_addr_a     = 5'($urandom_range(0, 7));
            rd_addr_b     = 5'($urandom_range(0, 7));
            #3;
            seen_ready = md_ready;
            cyc();
        end

        idle_inputs();
        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
